// File: rtl/vid_pkt_router.sv
// Avalon-ST video ingress router.
// Classifies packets by the header type nibble: video payload goes into a
// show-ahead FIFO, control packets update the frame geometry, and all other
// packet types are discarded and counted. Each video frame's beat count is
// checked against the last good geometry, and a per-frame flow result is
// reported.
module vid_pkt_router #(
   parameter int BITWIDTH          = 32,
   parameter int FIFO_DEPTH        = 16,
   parameter int DEPTH_WIDTH       = 4,
   parameter int ALMOST_FULL_DEPTH = 14,
   parameter int PIXELS_PER_BEAT   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BITWIDTH-1:0]    sink_data,
   input  logic                   sink_valid,
   input  logic                   sink_sop,
   input  logic                   sink_eop,
   output logic                   sink_ready,
   output logic [BITWIDTH-1:0]    source_data,
   output logic                   source_valid,
   output logic                   source_sop,
   output logic                   source_eop,
   input  logic                   source_ready,
   output logic                   fifo_empty,
   output logic [DEPTH_WIDTH:0]   fifo_level,
   output logic [15:0]            width,
   output logic [15:0]            height,
   output logic [3:0]             interlace,
   output logic                   control_valid,
   output logic                   control_error,
   output logic [2:0]             flow_result,
   output logic                   flow_valid,
   output logic [7:0]             drop_count
);

   localparam int ENTRY_W   = BITWIDTH + 2;
   localparam int PPB_SHIFT = (PIXELS_PER_BEAT == 4) ? 2 : ((PIXELS_PER_BEAT == 2) ? 1 : 0);
   localparam logic [31:0]          PPB_ROUND = 32'(PIXELS_PER_BEAT - 1);
   localparam logic [DEPTH_WIDTH:0] AF_LEVEL  = (DEPTH_WIDTH + 1)'(ALMOST_FULL_DEPTH);
   localparam logic [DEPTH_WIDTH:0] LVL_ONE   = (DEPTH_WIDTH + 1)'(1);
   localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = DEPTH_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VIDEO = 2'd1,
      ST_CTRL  = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   state_t                 state_r;
   logic [ENTRY_W-1:0]     mem_r [FIFO_DEPTH];
   logic [ENTRY_W-1:0]     head_s;
   logic [DEPTH_WIDTH-1:0] wr_ptr_r;
   logic [DEPTH_WIDTH-1:0] rd_ptr_r;
   logic [DEPTH_WIDTH:0]   level_r;
   logic [DEPTH_WIDTH:0]   level_nxt_s;
   logic                   empty_r;
   logic                   first_r;      // next video payload beat opens the frame
   logic [31:0]            beat_cnt_r;
   logic [31:0]            cnt_after_s;
   logic [31:0]            prod_s;
   logic [31:0]            expected_s;
   logic [2:0]             video_res_s;
   logic [35:0]            shadow_r;     // {width, height, interlace} being assembled
   logic [35:0]            shadow_nxt_s;
   logic [3:0]             ctrl_cnt_r;
   logic [3:0]             ctrl_cnt_nxt_s;
   logic                   geom_valid_r;
   logic                   sink_ready_s;
   logic                   accept_s;
   logic                   push_s;
   logic                   pop_s;

   logic [15:0]            width_r;
   logic [15:0]            height_r;
   logic [3:0]             interlace_r;
   logic                   control_valid_r;
   logic                   control_error_r;
   logic [2:0]             flow_result_r;
   logic                   flow_valid_r;
   logic [7:0]             drop_count_r;

   // Handshake, FIFO level, frame-length check and control nibble assembly.
   always_comb begin
      if (state_r == ST_VIDEO) begin
         sink_ready_s = (level_r < AF_LEVEL);
      end else begin
         sink_ready_s = 1'b1;
      end
      accept_s = sink_valid & sink_ready_s;
      push_s   = accept_s & ~sink_sop & (state_r == ST_VIDEO);
      pop_s    = ~empty_r & source_ready;

      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase

      prod_s      = {16'd0, width_r} * {16'd0, height_r};
      expected_s  = (prod_s + PPB_ROUND) >> PPB_SHIFT;
      cnt_after_s = beat_cnt_r + 32'd1;
      if (!geom_valid_r) begin
         video_res_s = 3'b001;
      end else if (cnt_after_s == expected_s) begin
         video_res_s = 3'b001;
      end else if (cnt_after_s < expected_s) begin
         video_res_s = 3'b010;
      end else begin
         video_res_s = 3'b100;
      end

      // Beats past the ninth payload nibble are ignored.
      if (ctrl_cnt_r < 4'd9) begin
         shadow_nxt_s   = {shadow_r[31:0], sink_data[3:0]};
         ctrl_cnt_nxt_s = ctrl_cnt_r + 4'd1;
      end else begin
         shadow_nxt_s   = shadow_r;
         ctrl_cnt_nxt_s = ctrl_cnt_r;
      end
   end

   // Packet state machine with registered geometry, status and drop count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r         <= ST_IDLE;
         first_r         <= 1'b0;
         beat_cnt_r      <= 32'd0;
         shadow_r        <= 36'd0;
         ctrl_cnt_r      <= 4'd0;
         geom_valid_r    <= 1'b0;
         width_r         <= 16'd0;
         height_r        <= 16'd0;
         interlace_r     <= 4'd0;
         control_valid_r <= 1'b0;
         control_error_r <= 1'b0;
         flow_result_r   <= 3'b000;
         flow_valid_r    <= 1'b0;
         drop_count_r    <= 8'd0;
      end else begin
         control_valid_r <= 1'b0;
         control_error_r <= 1'b0;
         flow_valid_r    <= 1'b0;

         // Payload beats of the packet in progress.
         if (accept_s && !sink_sop) begin
            case (state_r)
               ST_VIDEO: begin
                  beat_cnt_r <= cnt_after_s;
                  first_r    <= 1'b0;
                  if (sink_eop) begin
                     flow_valid_r  <= 1'b1;
                     flow_result_r <= video_res_s;
                     state_r       <= ST_IDLE;
                  end
               end
               ST_CTRL: begin
                  shadow_r   <= shadow_nxt_s;
                  ctrl_cnt_r <= ctrl_cnt_nxt_s;
                  if (sink_eop) begin
                     if (ctrl_cnt_nxt_s == 4'd9) begin
                        width_r         <= shadow_nxt_s[35:20];
                        height_r        <= shadow_nxt_s[19:4];
                        interlace_r     <= shadow_nxt_s[3:0];
                        geom_valid_r    <= 1'b1;
                        control_valid_r <= 1'b1;
                     end else begin
                        control_error_r <= 1'b1;
                     end
                     state_r <= ST_IDLE;
                  end
               end
               ST_DROP: begin
                  if (sink_eop) begin
                     state_r <= ST_IDLE;
                  end
               end
               default: begin
                  // Headerless beats in IDLE are discarded.
                  state_r <= ST_IDLE;
               end
            endcase
         end

         // A header terminates whatever was in progress and is classified now.
         if (accept_s && sink_sop) begin
            if (state_r == ST_VIDEO) begin
               flow_valid_r  <= 1'b1;
               flow_result_r <= 3'b010;
            end
            beat_cnt_r <= 32'd0;
            first_r    <= 1'b1;
            ctrl_cnt_r <= 4'd0;
            case (sink_data[3:0])
               4'h0: begin
                  if (sink_eop) begin
                     flow_valid_r  <= 1'b1;
                     flow_result_r <= 3'b010;
                     state_r       <= ST_IDLE;
                  end else begin
                     state_r <= ST_VIDEO;
                  end
               end
               4'hF: begin
                  if (sink_eop) begin
                     control_error_r <= 1'b1;
                     state_r         <= ST_IDLE;
                  end else begin
                     state_r <= ST_CTRL;
                  end
               end
               default: begin
                  if (drop_count_r != 8'hFF) begin
                     drop_count_r <= drop_count_r + 8'd1;
                  end
                  state_r <= sink_eop ? ST_IDLE : ST_DROP;
               end
            endcase
         end
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
         empty_r  <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r <= level_nxt_s;
         empty_r <= (level_nxt_s == '0);
      end
   end

   // FIFO storage: each entry is {eop, sop, data}.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {sink_eop, first_r, sink_data};
      end
   end

   assign head_s        = mem_r[rd_ptr_r];
   assign sink_ready    = sink_ready_s;
   assign source_valid  = ~empty_r;
   assign source_data   = empty_r ? '0   : head_s[BITWIDTH-1:0];
   assign source_sop    = empty_r ? 1'b0 : head_s[BITWIDTH];
   assign source_eop    = empty_r ? 1'b0 : head_s[BITWIDTH+1];
   assign fifo_empty    = empty_r;
   assign fifo_level    = level_r;
   assign width         = width_r;
   assign height        = height_r;
   assign interlace     = interlace_r;
   assign control_valid = control_valid_r;
   assign control_error = control_error_r;
   assign flow_result   = flow_result_r;
   assign flow_valid    = flow_valid_r;
   assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_vid_pkt_router.sv
// Scoreboard bench for vid_pkt_router: stimulus pushes expected source beats,
// flow results and control events into queues; monitors pop and compare.
module tb_vid_pkt_router;

   logic        clk;
   logic        rst;
   logic [31:0] sink_data;
   logic        sink_valid;
   logic        sink_sop;
   logic        sink_eop;
   logic        sink_ready;
   logic [31:0] source_data;
   logic        source_valid;
   logic        source_sop;
   logic        source_eop;
   logic        source_ready;
   logic        fifo_empty;
   logic [4:0]  fifo_level;
   logic [15:0] width;
   logic [15:0] height;
   logic [3:0]  interlace;
   logic        control_valid;
   logic        control_error;
   logic [2:0]  flow_result;
   logic        flow_valid;
   logic [7:0]  drop_count;

   int errors = 0;
   int checks = 0;

   logic [33:0] beat_q [$];   // {eop, sop, data}
   logic [2:0]  flow_q [$];
   logic [36:0] ctrl_q [$];   // {is_error, width, height, interlace}

   vid_pkt_router dut (
      .clk(clk), .rst(rst),
      .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
      .sink_eop(sink_eop), .sink_ready(sink_ready),
      .source_data(source_data), .source_valid(source_valid),
      .source_sop(source_sop), .source_eop(source_eop), .source_ready(source_ready),
      .fifo_empty(fifo_empty), .fifo_level(fifo_level),
      .width(width), .height(height), .interlace(interlace),
      .control_valid(control_valid), .control_error(control_error),
      .flow_result(flow_result), .flow_valid(flow_valid), .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got an event, expected none", name);
   endtask

   // Source monitor: a beat is consumed when valid and ready at the edge.
   always @(negedge clk) begin
      if (rst && source_valid && source_ready) begin
         if (beat_q.size() == 0) unexpected("src_beat");
         else check("src_beat", {30'd0, source_eop, source_sop, source_data}, {30'd0, beat_q.pop_front()});
      end
   end

   // Flow and control pulse monitor.
   always @(negedge clk) begin
      if (rst && flow_valid) begin
         if (flow_q.size() == 0) unexpected("flow");
         else check("flow_result", {61'd0, flow_result}, {61'd0, flow_q.pop_front()});
      end
      if (rst && (control_valid || control_error)) begin
         if (ctrl_q.size() == 0) unexpected("ctrl");
         else begin
            logic [36:0] e;
            e = ctrl_q.pop_front();
            check("ctrl_kind", {62'd0, control_valid, control_error}, {62'd0, ~e[36], e[36]});
            check("ctrl_geom", {28'd0, width, height, interlace}, {28'd0, e[35:0]});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
      int n;
      sink_data  = d;
      sink_sop   = s;
      sink_eop   = e;
      sink_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!sink_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!sink_ready) begin
         checks++;
         errors++;
         $display("FAIL sink_ready_wait: got 0 expected 1 within 300 cycles");
      end
      @(posedge clk);
      #1;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
   endtask

   // Video frame: header plus n payload beats, eop on the last one.
   task automatic send_video(input int n, input logic [31:0] base, input logic [2:0] res);
      for (int i = 0; i < n; i++) beat_q.push_back({(i == n - 1), (i == 0), base + 32'(i)});
      flow_q.push_back(res);
      send_beat(32'hABCD_0000, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) send_beat(base + 32'(i), 1'b0, (i == n - 1));
   endtask

   task automatic send_ctrl(input int n, input logic [35:0] nibbles, input logic [36:0] exp);
      ctrl_q.push_back(exp);
      send_beat(32'h1234_567F, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         logic [35:0] sh;
         sh = nibbles >> (4 * (8 - i));
         send_beat({28'h5A5A5A5, sh[3:0]}, 1'b0, (i == n - 1));
      end
   endtask

   task automatic send_drop();
      send_beat(32'h0000_0003, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(32'h0000_0000 + 32'(i), 1'b0, (i == 3));
   endtask

   task automatic check_reset_values();
      check("rst_sink_ready", {63'd0, sink_ready}, 64'd1);
      check("rst_fifo_empty", {63'd0, fifo_empty}, 64'd1);
      check("rst_source_valid", {63'd0, source_valid}, 64'd0);
      check("rst_source_bits", {30'd0, source_eop, source_sop, source_data}, 64'd0);
      check("rst_fifo_level", {59'd0, fifo_level}, 64'd0);
      check("rst_geometry", {28'd0, width, height, interlace}, 64'd0);
      check("rst_pulses", {58'd0, control_valid, control_error, flow_valid, flow_result}, 64'd0);
      check("rst_drop_count", {56'd0, drop_count}, 64'd0);
   endtask

   initial begin
      rst          = 1'b0;
      sink_data    = 32'd0;
      sink_valid   = 1'b0;
      sink_sop     = 1'b0;
      sink_eop     = 1'b0;
      source_ready = 1'b1;
      #12;
      check_reset_values();
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // Good control packet: width 4, height 2, interlace 3.
      send_ctrl(9, 36'h0004_0002_3, {1'b0, 16'd4, 16'd2, 4'd3});
      idle(3);
      check("geom_after_ctrl", {28'd0, width, height, interlace}, {28'd0, 16'd4, 16'd2, 4'd3});

      // Exact, short and long frames against 4x2 = 8 beats.
      send_video(8, 32'h1000_0000, 3'b001);
      idle(5);
      send_video(6, 32'h2000_0000, 3'b010);
      idle(5);
      send_video(10, 32'h3000_0000, 3'b100);
      idle(5);

      // Short control packet leaves geometry untouched.
      send_ctrl(4, 36'h1234_0000_0, {1'b1, 16'd4, 16'd2, 4'd3});
      idle(3);
      check("width_after_short_ctrl", {48'd0, width}, 64'd4);

      // Backpressure: sink_ready drops at level 14 and nothing is lost.
      source_ready = 1'b0;
      fork
         send_video(20, 32'h4000_0000, 3'b100);
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (fifo_level != 5'd14 && n < 200) begin
               n++;
               @(negedge clk);
            end
            check("bp_level_reached", {59'd0, fifo_level}, 64'd14);
            check("bp_sink_ready", {63'd0, sink_ready}, 64'd0);
            repeat (5) @(negedge clk);
            check("bp_level_hold", {59'd0, fifo_level}, 64'd14);
            @(posedge clk);
            #1;
            source_ready = 1'b1;
         end
      join
      idle(40);
      check("bp_drained", {63'd0, fifo_empty}, 64'd1);

      // Dropped packet types.
      send_drop();
      idle(2);
      check("drop_one", {56'd0, drop_count}, 64'd1);
      check("drop_no_fifo", {59'd0, fifo_level}, 64'd0);
      for (int i = 0; i < 299; i++) send_drop();
      idle(2);
      check("drop_saturated", {56'd0, drop_count}, 64'd255);

      // Header arriving mid-frame aborts the frame as short.
      for (int i = 0; i < 3; i++) beat_q.push_back({1'b0, (i == 0), 32'h5000_0000 + 32'(i)});
      flow_q.push_back(3'b010);
      send_beat(32'h0000_0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(32'h5000_0000 + 32'(i), 1'b0, 1'b0);
      send_video(8, 32'h6000_0000, 3'b001);
      idle(10);

      // Reset mid-frame with data parked in the FIFO.
      source_ready = 1'b0;
      send_beat(32'h0000_0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(32'h7000_0000 + 32'(i), 1'b0, 1'b0);
      check("pre_reset_level", {59'd0, fifo_level}, 64'd3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b1;
      source_ready = 1'b1;
      idle(2);

      // Geometry invalid after reset: length check disabled.
      send_video(5, 32'h8000_0000, 3'b001);
      idle(20);

      check("beat_q_empty", 64'(beat_q.size()), 64'd0);
      check("flow_q_empty", 64'(flow_q.size()), 64'd0);
      check("ctrl_q_empty", 64'(ctrl_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vid_pkt_router.md
Name: vid_pkt_router

Overview:
- Next-generation Avalon-ST video ingress block for the VIP pipeline.
- Classifies incoming packets by header type nibble:
  - 0x0 video: buffered in an internal FIFO.
  - 0xF control: decoded to width/height/interlace.
  - Any other type: dropped and counted.
- Checks each video frame's beat count against the last decoded geometry and reports a flow result per frame.

Parameters:
- BITWIDTH, 32, sink/source data width.
- FIFO_DEPTH, 16, video FIFO entries (power of two).
- DEPTH_WIDTH, 4, log2(FIFO_DEPTH).
- ALMOST_FULL_DEPTH, 14, FIFO level at or above which sink_ready is deasserted in VIDEO state.
- PIXELS_PER_BEAT, 1, pixels carried per video beat (1, 2 or 4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- sink_data  in  BITWIDTH  input data.
- sink_valid  in  1  input beat valid.
- sink_sop  in  1  start of packet (header beat).
- sink_eop  in  1  end of packet.
- sink_ready  out  1  input backpressure.
- source_data  out  BITWIDTH  video pixel data.
- source_valid  out  1  output beat valid.
- source_sop  out  1  first pixel beat of frame.
- source_eop  out  1  last pixel beat of frame.
- source_ready  in  1  downstream ready.
- fifo_empty  out  1  video FIFO empty.
- fifo_level  out  DEPTH_WIDTH+1  current FIFO occupancy.
- width  out  16  decoded frame width.
- height  out  16  decoded frame height.
- interlace  out  4  decoded interlace nibble.
- control_valid  out  1  one-cycle pulse on a good control packet.
- control_error  out  1  one-cycle pulse on a short control packet.
- flow_result  out  3  per-frame status: [0] ok, [1] short, [2] long.
- flow_valid  out  1  one-cycle pulse qualifying flow_result.
- drop_count  out  8  saturating count of dropped packets.

Behaviour:
- Reset (rst=0): all outputs 0, state IDLE, FIFO empty, geometry invalid. Exceptions: fifo_empty=1 and sink_ready=1.
- Beat acceptance: a beat is accepted when sink_valid & sink_ready.
- sink_ready:
  - 1 in IDLE, CTRL and DROP.
  - In VIDEO, equals (fifo_level < ALMOST_FULL_DEPTH), registered-free.
- State IDLE:
  - Accepted beat with sop: type = sink_data[3:0]. 0x0 → VIDEO, 0xF → CTRL, other → DROP.
  - Accepted beat without sop: discarded silently.
  - Header beat with sop&eop: handled per type, then returns to IDLE. Video in this case reports short; control reports error.
- State CTRL:
  - Payload beats 1..9 carry one nibble each in sink_data[3:0], MSB first: width[15:12]..[3:0], height[15:12]..[3:0], interlace.
  - Nibbles shift into shadow registers.
  - On accepted eop with ≥9 payload beats: width/height/interlace update next cycle, control_valid pulses, geometry marked valid.
  - Extra beats beyond 9 are ignored.
  - Eop with <9 payload beats: outputs unchanged, control_error pulses.
  - Return to IDLE.
- State VIDEO:
  - Header beat is not forwarded.
  - Each accepted payload beat is written to the FIFO as {eop, sop, data}. sop is set on the first payload beat.
  - beat_cnt (32-bit) increments per written beat.
  - On accepted eop: flow_valid pulses the next cycle, then return to IDLE.
  - Expected beats = ceil(width*height / PIXELS_PER_BEAT), computed at 32 bits.
  - flow_result: 3'b001 if count equals expected, 3'b010 if fewer, 3'b100 if more.
  - If geometry is invalid, result is 3'b001 (check disabled).
- State DROP: accept and discard until eop. drop_count increments once per dropped packet, saturating at 255. Return to IDLE.
- Sop mid-packet: the current packet is terminated and the new header is classified in the same cycle.
  - If the aborted packet was video: flow_valid pulses with 3'b010, and the last FIFO entry is not retro-marked.
  - An aborted control packet leaves the outputs unchanged.
- FIFO:
  - Show-ahead. source_* reflect the head entry; source_valid = !fifo_empty.
  - Pop when source_valid & source_ready.
  - Minimum latency from sink acceptance to source_valid: 1 cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by construction; pop from empty is ignored.
- Mid-operation reset clears the FIFO, counters and geometry immediately (asynchronous).

Test Plan:
- Control packet: header 0xF, then nibbles 0,0,0,4,0,0,0,2,3 with eop → width=4, height=2, interlace=3, control_valid pulses once.
- Video after that control packet: header 0x0 plus 8 beats, eop on the 8th → 8 beats out, sop on the first and eop on the last, flow_result=3'b001.
- Video with 6 beats → 3'b010. Video with 10 beats → 3'b100. Control packet of only 5 beats → control_error pulses and width stays 4.
- source_ready held 0 during a 20-beat frame → sink_ready drops when fifo_level reaches 14, no data is lost, and the output order is preserved after release.
- Header type 0x3 packet of 5 beats → no FIFO writes, drop_count=1. 300 such packets → drop_count=255.
- Sop arriving mid-video, plus rst asserted mid-frame → flow_result=3'b010 for the aborted frame. Reset case: outputs return to reset values and fifo_empty=1.
